// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the seven-segment display driver:
//   - conv_state_e : converter FSM states (IDLE, SHIFT, COMMIT)
//   - NUM_DIGITS   : number of multiplexed digits on the display
//   - SEG_BLANK    : active-low pattern with every segment off
//   - seg_decode() : hex digit to active-low segment pattern (seg[0]=a .. seg[6]=g)
// ---------------------------------------------------------------------------
package seg7_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } conv_state_e;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Common-anode display, so a segment is lit by driving it low.
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] pattern;
    case (digit)
      4'h0:    pattern = 7'h40;
      4'h1:    pattern = 7'h79;
      4'h2:    pattern = 7'h24;
      4'h3:    pattern = 7'h30;
      4'h4:    pattern = 7'h19;
      4'h5:    pattern = 7'h12;
      4'h6:    pattern = 7'h02;
      4'h7:    pattern = 7'h78;
      4'h8:    pattern = 7'h00;
      4'h9:    pattern = 7'h10;
      4'hA:    pattern = 7'h08;
      4'hB:    pattern = 7'h03;
      4'hC:    pattern = 7'h46;
      4'hD:    pattern = 7'h21;
      4'hE:    pattern = 7'h06;
      4'hF:    pattern = 7'h0E;
      default: pattern = SEG_BLANK;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/seg7_display_driver_bcd.sv
// ---------------------------------------------------------------------------
// bin16_to_bcd
// Sequential double-dabble converter: 16-bit binary to 20-bit BCD, one
// iteration per clock, 16 iterations per conversion.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   start_i      : load bin_i and clear the BCD register and bit counter
//   bin_i        : binary value sampled on start_i
//   busy_o       : iterations still outstanding
//   done_o       : high during the cycle whose edge performs the final
//                  iteration, so bcd_o is complete right after that edge
//   bcd_o        : BCD result (five digits, [19:16] is the ten-thousands)
// ---------------------------------------------------------------------------
module bin16_to_bcd (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_i,
  input  logic [15:0] bin_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [19:0] bcd_o
);

  logic [19:0] bcd_q, bcd_d;
  logic [15:0] shadow_q, shadow_d;
  logic [3:0]  count_q, count_d;
  logic        busy_q, busy_d;
  logic [19:0] adj;

  // Add-3 correction on every BCD nibble that is 5 or more, then shift the
  // corrected BCD and the binary shadow left together as one long register.
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < 5; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end

    bcd_d    = bcd_q;
    shadow_d = shadow_q;
    count_d  = count_q;
    busy_d   = busy_q;

    if (start_i) begin
      bcd_d    = '0;
      shadow_d = bin_i;
      count_d  = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      bcd_d    = {adj[18:0], shadow_q[15]};
      shadow_d = {shadow_q[14:0], 1'b0};
      count_d  = count_q + 4'd1;
      if (count_q == 4'd15) begin
        busy_d = 1'b0;
      end
    end
  end

  // Converter state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bcd_q    <= '0;
      shadow_q <= '0;
      count_q  <= '0;
      busy_q   <= 1'b0;
    end else begin
      bcd_q    <= bcd_d;
      shadow_q <= shadow_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = busy_q && (count_q == 4'd15);
  assign bcd_o  = bcd_q;

endmodule

// File: rtl/seg7_display_driver.sv
// ---------------------------------------------------------------------------
// seg7_display_driver
// Shows a 16-bit debug value on a multiplexed common-anode 4-digit
// seven-segment display, in hex or decimal. Decimal goes through the
// sequential double-dabble engine; the shown digits only ever change at a
// commit, so a partial conversion is never visible.
// Parameters:
//   REFRESH_DIV   : clock cycles each digit stays lit (>= 2)
//   BLANK_LEADING : 1 blanks leading zero digits (digit 0 is never blanked)
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   value        : value to display
//   hex_mode     : 1 = hexadecimal, 0 = decimal
//   seg          : active-low segments, seg[0]=a .. seg[6]=g
//   dp           : active-low decimal point, lit on all digits on overflow
//   an           : active-low anodes, an[0] = rightmost digit
//   conv_busy    : capture/conversion in progress
// ---------------------------------------------------------------------------
module seg7_display_driver
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV   = 50000,
  parameter int BLANK_LEADING = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] value,
  input  logic        hex_mode,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        conv_busy
);

  localparam int               CNT_W    = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  conv_state_e      state_q;
  logic [15:0]      last_value_q;
  logic             last_mode_q;
  logic [15:0]      pend_q;
  logic [15:0]      digits_q;
  logic             ovf_q;
  logic [CNT_W-1:0] refresh_q;
  logic [1:0]       idx_q;
  logic [3:0]       an_q;
  logic [6:0]       seg_q;
  logic             dp_q;

  logic             changed;
  logic             bcd_start;
  logic             bcd_busy;
  logic             bcd_done;
  logic [19:0]      bcd;
  logic [3:0]       cur_digit;
  logic             upper_zero;
  logic             blank;

  // Changes are only looked at in IDLE; anything that arrives mid-conversion
  // is picked up by this same compare once the FSM is back in IDLE.
  assign changed   = (state_q == ST_IDLE) &&
                     ((value != last_value_q) || (hex_mode != last_mode_q));
  assign bcd_start = changed && !hex_mode;

  bin16_to_bcd u_bcd (
    .clk     (clk),
    .reset_n (reset_n),
    .start_i (bcd_start),
    .bin_i   (value),
    .busy_o  (bcd_busy),
    .done_o  (bcd_done),
    .bcd_o   (bcd)
  );

  // Converter FSM: capture on change, wait for the BCD engine in decimal,
  // then copy the finished digits into the displayed registers in COMMIT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      last_value_q <= '0;
      last_mode_q  <= 1'b0;
      pend_q       <= '0;
      digits_q     <= '0;
      ovf_q        <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (changed) begin
            last_value_q <= value;
            last_mode_q  <= hex_mode;
            if (hex_mode) begin
              pend_q  <= value;
              state_q <= ST_COMMIT;
            end else begin
              state_q <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          // done marks the final shift edge, so the result is ready in COMMIT.
          if (bcd_busy && bcd_done) begin
            state_q <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          if (last_mode_q) begin
            digits_q <= pend_q;
            ovf_q    <= 1'b0;
          end else begin
            digits_q <= bcd[15:0];
            ovf_q    <= |bcd[19:16];
          end
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Current digit and leading-zero blanking: a digit is blanked when it and
  // every digit to its left are zero.
  always_comb begin
    cur_digit  = digits_q[{idx_q, 2'b00} +: 4];
    upper_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((i >= int'(idx_q)) && (digits_q[4*i +: 4] != 4'd0)) begin
        upper_zero = 1'b0;
      end
    end
    blank = (BLANK_LEADING != 0) && (idx_q != 2'd0) && upper_zero;
  end

  // Scanner: refresh counter steps the digit index, outputs are registered
  // from the index and digits as they stood before this edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      refresh_q <= '0;
      idx_q     <= '0;
      an_q      <= 4'hF;
      seg_q     <= SEG_BLANK;
      dp_q      <= 1'b1;
    end else begin
      if (refresh_q == CNT_LAST) begin
        refresh_q <= '0;
        idx_q     <= idx_q + 2'd1;
      end else begin
        refresh_q <= refresh_q + CNT_W'(1);
      end
      an_q  <= ~(4'b0001 << idx_q);
      seg_q <= blank ? SEG_BLANK : seg_decode(cur_digit);
      dp_q  <= ~ovf_q;
    end
  end

  assign an        = an_q;
  assign seg       = seg_q;
  assign dp        = dp_q;
  assign conv_busy = (state_q != ST_IDLE);

endmodule
